// File: rtl/ssd_driver.sv
// ssd_driver: four-digit common-anode seven-segment driver.
// A sequential double-dabble converter turns the 13-bit binary input into
// four BCD digits. The digits are held in a display buffer and scanned onto
// the anodes at a rate set by REFRESH_DIV.
// Optional feature macro: SSD_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module ssd_driver #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [12:0] value,
   output logic [3:0]  anode,
   output logic [6:0]  cathode,
   output logic        busy
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

   state_t        state_q, state_d;
   logic [12:0]   cap_q, cap_d;
   logic [12:0]   bin_q, bin_d;
   logic [15:0]   bcd_q, bcd_d;
   logic [15:0]   buf_q, buf_d;
   logic [3:0]    bitcnt_q, bitcnt_d;
   logic          force_q, force_d;
   logic          busy_q, busy_d;
   logic [15:0]   adj;
   logic [28:0]   shifted;

   logic [CW-1:0] refcnt_q;
   logic [1:0]    idx_q;
   logic [3:0]    anode_q;
   logic [6:0]    cathode_q;
   logic [3:0]    nib;
   logic [6:0]    seg_d;

   // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles stay dark.
   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      case (n)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
      logic [15:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

   // Converter next-state: capture on change (or forced after reset), shift 13 times, publish.
   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      buf_d    = buf_q;
      bitcnt_d = bitcnt_q;
      force_d  = force_q;
      busy_d   = busy_q;
      adj      = dabble_adjust(bcd_q);
      shifted  = {adj, bin_q} << 1;
      case (state_q)
         IDLE: begin
            if (force_q || (value != cap_q)) begin
               cap_d    = value;
               bin_d    = value;
               bcd_d    = 16'd0;
               force_d  = 1'b0;
               bitcnt_d = 4'd12;
               busy_d   = 1'b1;
               state_d  = CONVERT;
            end
         end
         CONVERT: begin
            {bcd_d, bin_d} = shifted;
            if (bitcnt_q == 4'd0) state_d = UPDATE;
            else                  bitcnt_d = bitcnt_q - 4'd1;
         end
         UPDATE: begin
            buf_d   = bcd_q;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Converter state and the buffer/capture registers that have defined reset values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         cap_q    <= 13'd0;
         buf_q    <= 16'd0;
         bitcnt_q <= 4'd0;
         force_q  <= 1'b1;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cap_q    <= cap_d;
         buf_q    <= buf_d;
         bitcnt_q <= bitcnt_d;
         force_q  <= force_d;
         busy_q   <= busy_d;
      end
   end

   // Scratch shift registers; always reloaded at capture, so they need no reset.
   always_ff @(posedge clk) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
   end

   // Select the buffer nibble for the digit being scanned and form its segments.
   always_comb begin
      case (idx_q)
         2'd0:    nib = buf_q[3:0];
         2'd1:    nib = buf_q[7:4];
         2'd2:    nib = buf_q[11:8];
         default: nib = buf_q[15:12];
      endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
      case (idx_q)
         2'd1:    seg_d = (buf_q[15:4] == 12'd0) ? 7'b1111111 : seg_decode(nib);
         2'd2:    seg_d = (buf_q[15:8] == 8'd0)  ? 7'b1111111 : seg_decode(nib);
         2'd3:    seg_d = (buf_q[15:12] == 4'd0) ? 7'b1111111 : seg_decode(nib);
         default: seg_d = seg_decode(nib);
      endcase
`else
      seg_d = seg_decode(nib);
`endif
   end

   // Refresh divider, digit index and registered anode/cathode outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         refcnt_q  <= '0;
         idx_q     <= 2'd0;
         anode_q   <= 4'b1111;
         cathode_q <= 7'b1111111;
      end else begin
         if (refcnt_q == REF_LAST) begin
            refcnt_q <= '0;
            idx_q    <= idx_q + 2'd1;
         end else begin
            refcnt_q <= refcnt_q + 1'b1;
         end
         anode_q   <= ~(4'b0001 << idx_q);
         cathode_q <= seg_d;
      end
   end

   assign anode   = anode_q;
   assign cathode = cathode_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_ssd_driver.sv
// Scoreboard bench for ssd_driver with a short refresh period.
module tb_ssd_driver;

   localparam int RDIV = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [12:0] value = 13'd0;
   logic [3:0]  anode;
   logic [6:0]  cathode;
   logic        busy;

   ssd_driver #(.REFRESH_DIV(RDIV)) dut (
      .clk     (clk),
      .rst     (rst),
      .value   (value),
      .anode   (anode),
      .cathode (cathode),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   busy_run = 0;
   int   last_len = 0;
   int   done_pending = 0;
   int   done_cyc = 0;
   int   rel_cyc = 0;
   logic busy_prev = 1'b0;
   int   exp_q[$];

   task automatic chk(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // One clock step, sampled on the falling edge; tracks busy pulses and completions.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (busy) begin
         busy_run++;
      end else begin
         if (busy_prev && rst) begin
            done_pending++;
            done_cyc = cyc;
            last_len = busy_run;
         end
         busy_run = 0;
      end
      busy_prev = busy;
   endtask

   function automatic logic [6:0] exp_seg(input int v, input int d);
      int   x;
      int   p;
      logic [6:0] s;
      x = v;
      p = 1;
      for (int k = 0; k < d; k++) begin
         x = x / 10;
         p = p * 10;
      end
      case (x % 10)
         0: s = 7'b1000000;
         1: s = 7'b1111001;
         2: s = 7'b0100100;
         3: s = 7'b0110000;
         4: s = 7'b0011001;
         5: s = 7'b0010010;
         6: s = 7'b0000010;
         7: s = 7'b1111000;
         8: s = 7'b0000000;
         default: s = 7'b0010000;
      endcase
`ifdef SSD_LEADING_ZERO_BLANK_EN
      if (d > 0 && v < p) s = 7'b1111111;
`endif
      return s;
   endfunction

   // Watch the scan for n cycles and check every shown digit against value v.
   task automatic check_display(input int v, input int n);
      int run;
      int prev;
      int idx;
      bit seen_change;
      run = 0;
      prev = -1;
      seen_change = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         case (anode)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         chk("anode_onehot", int'(idx >= 0), 1);
         if (idx >= 0) begin
            chk($sformatf("cathode_v%0d_d%0d", v, idx), int'(cathode), int'(exp_seg(v, idx)));
            if (prev >= 0 && idx != prev) begin
               chk("scan_order", idx, (prev + 1) % 4);
               if (seen_change) chk("dwell", run, RDIV);
               seen_change = 1;
               run = 0;
            end
            run++;
            prev = idx;
         end
      end
   endtask

   // Wait for a conversion to finish, then compare the display with the scoreboard head.
   task automatic conv_check(input int nsamp);
      int n;
      int e;
      n = 0;
      while (done_pending == 0 && n < 200) begin
         tick();
         n++;
      end
      chk("conv_done", int'(done_pending > 0), 1);
      if (done_pending > 0) begin
         done_pending--;
         chk("busy_len", last_len, 14);
         chk("sb_nonempty", int'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_display(e, nsamp);
         end
      end
   endtask

   task automatic wait_busy();
      int n;
      n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      chk("busy_rise", int'(busy), 1);
   endtask

   initial begin
      int cnt;
      rst   = 1'b0;
      value = 13'd0;
      repeat (3) tick();
      chk("rst_anode", int'(anode), 4'hF);
      chk("rst_cathode", int'(cathode), 7'h7F);
      chk("rst_busy", int'(busy), 0);

      // First conversion after reset release.
      rel_cyc = cyc;
      rst = 1'b1;
      exp_q.push_back(0);
      conv_check(20);
      chk("latency_init", done_cyc - rel_cyc, 15);

      // Full-scale value.
      value = 13'd8191;
      exp_q.push_back(8191);
      conv_check(20);

      // Two-digit value (leading zeros shown or blanked).
      value = 13'd42;
      exp_q.push_back(42);
      conv_check(20);

      // Input changes in the middle of a conversion.
      value = 13'd100;
      exp_q.push_back(100);
      wait_busy();
      repeat (4) tick();
      value = 13'd205;
      exp_q.push_back(205);
      conv_check(15);
      conv_check(20);

      // Reset during a conversion of 1234.
      value = 13'd1234;
      wait_busy();
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("midrst_anode", int'(anode), 4'hF);
      chk("midrst_cathode", int'(cathode), 7'h7F);
      chk("midrst_busy", int'(busy), 0);
      tick();
      rel_cyc = cyc;
      rst = 1'b1;
      exp_q.push_back(1234);
      check_display(0, 4);
      conv_check(20);
      chk("latency_rst", done_cyc - rel_cyc, 15);

      // Stable input: no further conversions.
      cnt = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (busy) cnt++;
      end
      chk("hold_busy", cnt, 0);
      chk("hold_done", done_pending, 0);
      check_display(1234, 16);
      chk("sb_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
